brc_serial_cmp: RTL and testbench
=================================

# brc_serial_cmp

Multi-cycle signed/unsigned magnitude comparator for the branch-compare and SLT/SLTU path. It scans operands digit-serially from the MSB down, the opposite direction to the LSB-first carry chain of the single-cycle subtract-based comparator. It trades latency for area: one DIGIT-wide compare per cycle instead of a full 32-bit subtractor. A valid/ready handshake sits on both sides, so it drops into the multi-cycle execute slot next to the ALU.

## Interface
- WIDTH, 32: operand width; must be a multiple of DIGIT.
- DIGIT, 4: bits compared per cycle. NDIG = WIDTH/DIGIT (8 at defaults).
- i_clk  input  1  clock, all logic on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_valid  input  1  request valid.
- o_ready  output  1  block can accept a request (high only in IDLE).
- i_a  input  WIDTH  operand A.
- i_b  input  WIDTH  operand B.
- i_unsigned  input  1  1 = unsigned compare (SLTU/BLTU), 0 = signed.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts result.
- o_less  output  1  A < B under the selected signedness.
- o_equal  output  1  A == B.
- o_slt  output  WIDTH  zero-extended o_less (32'h00000001 or 32'h00000000).

## Operation
- States: IDLE, SCAN, DONE. Digit counter cnt is 0..NDIG-1, where 0 is the most-significant digit.
- IDLE: o_ready = 1. When i_valid & o_ready, the block captures i_a, i_b, i_unsigned, sets cnt = 0, clears the decided flag, and moves to SCAN.
- Sign handling: on capture with i_unsigned = 0, bit WIDTH-1 of both captured operands is inverted. The signed compare then reduces to an unsigned compare with no other special case.
- SCAN, each cycle: compare digit cnt of A against digit cnt of B as unsigned.
  - If the digits differ and decided = 0: record less = (digitA < digitB), equal = 0, set decided = 1.
  - Later digits never change a recorded decision.
  - If cnt == NDIG-1, or (the digits differ and early exit is enabled), go to DONE.
  - Otherwise increment cnt.
- If no digit differs: equal = 1, less = 0.
- DONE: o_valid = 1. o_less, o_equal and o_slt are held stable until o_valid & i_ready, then the block returns to IDLE.
- No overlap: a new request is accepted only in IDLE, so at least one idle cycle separates results.
- Operands are held in internal registers. i_a, i_b and i_unsigned are don't-care after the accept cycle.

## Timing
- Reset (i_reset high at a clock edge): state = IDLE, o_ready = 1, o_valid = 0, o_less = 0, o_equal = 0, o_slt = 0, cnt = 0.
- Reset mid-SCAN or in DONE aborts the operation. No o_valid is produced for it, and the pending result is discarded.
- Accept in cycle N. The first differing digit index is d (0 = MSB).
  - With early exit enabled: o_valid rises in cycle N+d+2.
  - Equal operands: o_valid rises in cycle N+NDIG+1 (N+9 at defaults).
- In DONE with i_ready held low, o_valid and all result outputs stay constant indefinitely.
- o_ready is high again in the cycle after the result handshake.
- i_valid in SCAN or DONE is ignored; the requester must hold it until o_ready.

## Configuration
- BRC_EARLY_EXIT_EN defined: SCAN terminates on the first differing digit, giving variable latency of 2..NDIG+1 cycles after accept.
- BRC_EARLY_EXIT_EN undefined: SCAN always runs all NDIG digits, giving a fixed latency of N+NDIG+1. The decided flag still keeps the first difference.
- Results are identical in both builds; only latency differs.

## Test plan
- Signed: A = 32'hFFFFFFFF (-1), B = 32'h00000001, i_unsigned = 0, accept at N -> o_less = 1, o_equal = 0, o_slt = 1. o_valid at N+2 (early exit) or N+9 (no early exit).
- Unsigned: same operands with i_unsigned = 1 -> o_less = 0, o_equal = 0, o_slt = 0, same latencies as above.
- Signed boundary: A = 32'h80000000, B = 32'h7FFFFFFF -> o_less = 1. Swap the operands -> o_less = 0.
- Equal and LSB-digit cases:
  - A = B = 32'h12345678 -> o_equal = 1, o_less = 0, o_valid at N+9 in both builds.
  - A = 32'h00000010, B = 32'h00000011 (d = 7) -> o_less = 1 at N+9.
- Backpressure: hold i_ready = 0 for 5 cycles after o_valid -> outputs stable and o_ready = 0 throughout. i_ready = 1 -> o_ready = 1 in the next cycle. A back-to-back second request is accepted that cycle.
- Reset mid-SCAN: assert i_reset at N+3 -> the next cycle shows IDLE, o_valid = 0, o_less = 0, o_slt = 0, o_ready = 1. A fresh request completes correctly afterwards.

Source files
------------

// File: rtl/brc_serial_cmp_if.sv
// rtl/brc_serial_cmp_if.sv - request/result handshake bundle for the digit-serial comparator
interface brc_serial_cmp_if #(
    parameter int WIDTH = 32
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_unsigned;
    logic             o_valid;
    logic             i_ready;
    logic             o_less;
    logic             o_equal;
    logic [WIDTH-1:0] o_slt;

    modport master (
        output i_valid, i_a, i_b, i_unsigned, i_ready,
        input  o_ready, o_valid, o_less, o_equal, o_slt
    );

    modport slave (
        input  i_valid, i_a, i_b, i_unsigned, i_ready,
        output o_ready, o_valid, o_less, o_equal, o_slt
    );
endinterface

// File: rtl/brc_serial_cmp.sv
// rtl/brc_serial_cmp.sv - MSB-first digit-serial signed/unsigned comparator; BRC_EARLY_EXIT_EN stops at first differing digit
module brc_serial_cmp #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    brc_serial_cmp_if.slave cmp
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);
    localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef BRC_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             decided_q;
    logic             less_q;
    logic             equal_q;

    logic [DIGIT-1:0] digit_a, digit_b;
    logic             differ;
    logic             accept;
    logic             last;

    // Operands shift left each SCAN cycle, so the digit under test is always the top one
    assign digit_a = a_q[WIDTH-1 -: DIGIT];
    assign digit_b = b_q[WIDTH-1 -: DIGIT];
    assign differ  = (digit_a != digit_b);
    assign last    = (cnt_q == LAST);
    assign accept  = (state_q == IDLE) && cmp.i_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (cmp.i_valid) state_d = SCAN;
            SCAN: if (last || (EARLY_EXIT && differ)) state_d = DONE;
            DONE: if (cmp.i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            decided_q <= 1'b0;
            less_q    <= 1'b0;
            equal_q   <= 1'b0;
        end else if (accept) begin
            // Flipping both sign bits maps two's-complement order onto unsigned order
            a_q       <= cmp.i_a ^ (cmp.i_unsigned ? '0 : SIGN_MASK);
            b_q       <= cmp.i_b ^ (cmp.i_unsigned ? '0 : SIGN_MASK);
            cnt_q     <= '0;
            decided_q <= 1'b0;
            less_q    <= 1'b0;
            equal_q   <= 1'b1;
        end else if (state_q == SCAN) begin
            if (differ && !decided_q) begin
                less_q    <= (digit_a < digit_b);
                equal_q   <= 1'b0;
                decided_q <= 1'b1;
            end
            a_q <= a_q << DIGIT;
            b_q <= b_q << DIGIT;
            if (state_d == SCAN) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cmp.o_ready = (state_q == IDLE);
    assign cmp.o_valid = (state_q == DONE);
    assign cmp.o_less  = less_q;
    assign cmp.o_equal = equal_q;
    assign cmp.o_slt   = {{(WIDTH-1){1'b0}}, less_q};
endmodule

// File: tb/tb_brc_serial_cmp.sv
// tb/tb_brc_serial_cmp.sv - directed self-checking bench for brc_serial_cmp
module tb_brc_serial_cmp;
    localparam int WIDTH = 32;
    localparam int NDIG  = 8;

    logic i_clk = 1'b0;
    logic i_reset;
    int   n_checks = 0;
    int   n_errors = 0;

    brc_serial_cmp_if #(.WIDTH(WIDTH)) cmp ();

    brc_serial_cmp #(.WIDTH(WIDTH), .DIGIT(4)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .cmp     (cmp.slave)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int exp_latency(input bit eq, input int d);
`ifdef BRC_EARLY_EXIT_EN
        return eq ? NDIG + 1 : d + 2;
`else
        return NDIG + 1;
`endif
    endfunction

    // Drives one request at a negedge, measures cycles from accept to o_valid, checks results,
    // optionally stalls the result for hold cycles, then completes the handshake.
    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input bit uns, input bit exp_less, input bit exp_eq, input int d,
                       input int hold);
        int lat;
        check({tag, "_ready_in"}, 32'(cmp.o_ready), 32'd1);
        cmp.i_valid    = 1'b1;
        cmp.i_a        = a;
        cmp.i_b        = b;
        cmp.i_unsigned = uns;
        @(posedge i_clk);
        @(negedge i_clk);
        cmp.i_valid    = 1'b0;
        cmp.i_a        = ~a;
        cmp.i_b        = 32'h0;
        cmp.i_unsigned = ~uns;
        lat = 1;
        while (!cmp.o_valid && lat < 40) begin
            @(negedge i_clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_latency(exp_eq, d)));
        check({tag, "_less"}, 32'(cmp.o_less), 32'(exp_less));
        check({tag, "_equal"}, 32'(cmp.o_equal), 32'(exp_eq));
        check({tag, "_slt"}, cmp.o_slt, {31'b0, exp_less});
        for (int i = 0; i < hold; i++) begin
            @(negedge i_clk);
            check({tag, "_hold_valid"}, 32'(cmp.o_valid), 32'd1);
            check({tag, "_hold_ready"}, 32'(cmp.o_ready), 32'd0);
            check({tag, "_hold_slt"}, cmp.o_slt, {31'b0, exp_less});
            check({tag, "_hold_equal"}, 32'(cmp.o_equal), 32'(exp_eq));
        end
        cmp.i_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        cmp.i_ready = 1'b0;
        check({tag, "_ready_after"}, 32'(cmp.o_ready), 32'd1);
        check({tag, "_valid_after"}, 32'(cmp.o_valid), 32'd0);
    endtask

    initial begin
        int k;
        i_reset        = 1'b1;
        cmp.i_valid    = 1'b0;
        cmp.i_a        = '0;
        cmp.i_b        = '0;
        cmp.i_unsigned = 1'b0;
        cmp.i_ready    = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_ready", 32'(cmp.o_ready), 32'd1);
        check("rst_valid", 32'(cmp.o_valid), 32'd0);
        check("rst_less", 32'(cmp.o_less), 32'd0);
        check("rst_equal", 32'(cmp.o_equal), 32'd0);
        check("rst_slt", cmp.o_slt, 32'd0);
        i_reset = 1'b0;
        @(negedge i_clk);

        run("s_neg1_1",   32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b0, 0, 5);
        run("u_ffff_1",   32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0, 0, 0);
        run("s_min_max",  32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 0, 0);
        run("s_max_min",  32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b0, 1'b0, 0, 0);
        run("equal",      32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b1, 0, 0);
        run("lsb_digit",  32'h00000010, 32'h00000011, 1'b1, 1'b1, 1'b0, 7, 0);
        run("mid_digit",  32'h00500000, 32'h00400000, 1'b1, 1'b0, 1'b0, 2, 2);
        run("s_neg_neg",  32'hFFFFFFF0, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 7, 0);

        // Abort a request with a reset in cycle N+3
        cmp.i_valid    = 1'b1;
        cmp.i_a        = 32'hFFFFFFFF;
        cmp.i_b        = 32'h00000001;
        cmp.i_unsigned = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        cmp.i_valid = 1'b0;
        k = 1;
        while (k < 3) begin
            @(negedge i_clk);
            k++;
        end
        i_reset = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        check("abort_ready", 32'(cmp.o_ready), 32'd1);
        check("abort_valid", 32'(cmp.o_valid), 32'd0);
        check("abort_less", 32'(cmp.o_less), 32'd0);
        check("abort_slt", cmp.o_slt, 32'd0);
        @(negedge i_clk);
        check("abort_no_valid", 32'(cmp.o_valid), 32'd0);
        run("post_abort", 32'h00000003, 32'h00000002, 1'b1, 1'b0, 1'b0, 7, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
